// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter that pulls bytes from a FIFO with 1-cycle read latency.
// All outputs are registered from the next-state values so they align with the state register.
module fifo_uart_tx #(
  parameter int CLOCKS_PER_BIT = 868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_empty,
  input  logic        enable,
  output logic        fifo_read,
  output logic        tx,
  output logic        busy,
  output logic [15:0] sent_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  localparam logic [15:0] LAST_TICK = 16'(CLOCKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] count_q, count_d;
  logic        tx_q, tx_d;
  logic        fifo_read_q, fifo_read_d;
  logic        busy_q, busy_d;
  logic        bit_done;

  assign bit_done = (timer_q == LAST_TICK);

  // Next-state, bit timing and datapath updates
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        timer_d = 16'd0;
        if (enable && !fifo_empty) begin
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        timer_d = 16'd0;
        state_d = LOAD;
      end
      LOAD: begin
        timer_d   = 16'd0;
        shift_d   = fifo_data;
        bit_idx_d = 3'd0;
        state_d   = START;
      end
      START: begin
        if (bit_done) begin
          timer_d   = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_done) begin
          timer_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (bit_done) begin
          timer_d = 16'd0;
          count_d = count_q + 16'd1;
          // Decide on the next fetch only at frame end; enable mid-frame has no effect
          if (enable && !fifo_empty) begin
            state_d = READ;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        timer_d = 16'd0;
        state_d = IDLE;
      end
    endcase
  end

  // Output values derived from the upcoming state so the registered outputs track state_q
  always_comb begin
    fifo_read_d = (state_d == READ);
    busy_d      = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= 16'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      count_q     <= 16'd0;
      tx_q        <= 1'b1;
      fifo_read_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      tx_q        <= tx_d;
      fifo_read_q <= fifo_read_d;
      busy_q      <= busy_d;
    end
  end

  assign fifo_read  = fifo_read_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign sent_count = count_q;

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have one parameter: CLOCKS_PER_BIT, default 868, clock cycles per UART bit (legal range 2..65535).
REQ-002 The block SHALL use one clock, clock; reset is synchronous and active-high, reset.
REQ-003 Ports, in order:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous active-high reset
- fifo_data  input  8  byte from the FIFO read port, valid the cycle after fifo_read
- fifo_empty  input  1  FIFO empty flag
- enable  input  1  permission to start new frames
- fifo_read  output  1  one-cycle FIFO pop strobe
- tx  output  1  serial line, idle high
- busy  output  1  high whenever the state is not IDLE
- sent_count  output  16  count of completed frames

Function
REQ-004 The block SHALL drain bytes from a FIFO with 1-cycle read latency and transmit each byte as UART 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-005 The state machine SHALL have six states: IDLE, READ, LOAD, START, DATA, STOP.
REQ-006 In IDLE, if enable=1 and fifo_empty=0, the next state SHALL be READ; otherwise the FSM SHALL stay in IDLE.
REQ-007 In READ (exactly 1 cycle), fifo_read SHALL be 1; in every other state fifo_read SHALL be 0.
REQ-008 In LOAD (exactly 1 cycle), the shift register SHALL capture fifo_data at the ending edge, and the next state SHALL be START.
REQ-009 START, each of the 8 DATA bits, and STOP SHALL each last exactly CLOCKS_PER_BIT cycles, timed by a 16-bit bit timer that is cleared on every state or bit change.
REQ-010 In DATA, a 3-bit bit index SHALL select the bits; after bit 7 completes, the next state SHALL be STOP.
REQ-011 tx SHALL be 0 in START, equal to the shift-register bit in DATA, and 1 in IDLE, READ, LOAD and STOP; tx SHALL be registered and glitch-free.
REQ-012 On the last STOP cycle, sent_count SHALL increment by 1, wrapping from 65535 to 0.
REQ-013 On the last STOP cycle, the next state SHALL be READ if enable=1 and fifo_empty=0, otherwise IDLE; back-to-back frames therefore have a period of CLOCKS_PER_BIT*10+2 cycles.
REQ-014 busy SHALL be 1 in READ, LOAD, START, DATA and STOP.
REQ-015 Changes to enable or fifo_empty after READ SHALL NOT affect the frame in progress; enable=0 only prevents the next fetch.
REQ-016 fifo_read SHALL never be asserted while fifo_empty=1 in the same cycle.

Reset
REQ-017 When reset=1 at a clock edge, all of the following SHALL hold on the next cycle, regardless of state:
- state=IDLE, tx=1, fifo_read=0, busy=0
- sent_count=0, bit timer=0, bit index=0
REQ-018 A reset mid-frame SHALL abort the frame: the popped byte is discarded, tx returns high, and no stop bit is emitted.
REQ-019 reset SHALL take priority over every other input.

Verification (CLOCKS_PER_BIT=4)
REQ-020 Reset: assert reset for 2 cycles with fifo_empty=0 and enable=1 -> during reset, tx=1, busy=0, fifo_read=0, sent_count=0.
REQ-021 Single byte: fifo_data=0xA5, fifo_read seen high at cycle N ->
- tx=0 for N+2..N+5
- data bits 1,0,1,0,0,1,0,1, each 4 cycles, N+6..N+37
- tx=1 for N+38..N+41
- sent_count=1, busy=0 at N+42
REQ-022 Back-to-back: FIFO holds 0x00, 0xFF, 0x3C with enable=1 -> fifo_read pulses exactly 42 cycles apart, busy stays 1 throughout, sent_count=3 at the end, and the serial waveform decodes to 0x00, 0xFF, 0x3C.
REQ-023 Empty or disabled: fifo_empty=1 (or enable=0) for 100 cycles -> fifo_read never asserted, tx=1, busy=0.
REQ-024 Enable dropped mid-DATA with the FIFO non-empty -> the current frame completes with a correct stop bit, and there is no further fifo_read.
REQ-025 Reset mid-DATA -> on the next cycle tx=1, busy=0, sent_count=0; the next frame starts cleanly from READ when reset is released.
